// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator stream decimator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WIN_MIN_LOG2_DEF = 5;
    localparam int RESULT_W         = 8;
    localparam int CNT_W            = RESULT_W + 1;

    // Normalise a ones count taken over 2^l samples to a RESULT_W-bit code.
    // A full-scale window (all ones) lands one past the top code, so saturate.
    function automatic logic [RESULT_W-1:0] scale_code(input logic [31:0] ones,
                                                       input int          l);
        logic [39:0] wide;
        wide = {8'd0, ones};
        if (l < RESULT_W) begin
            wide = wide << (RESULT_W - l);
        end else begin
            wide = wide >> (l - RESULT_W);
        end
        if (wide > 40'((1 << RESULT_W) - 1)) begin
            return '1;
        end
        return wide[RESULT_W-1:0];
    endfunction

endpackage

// File: rtl/cmp_sync.sv
// Multi-flop synchronizer bringing the asynchronous comparator decision into clk.
module cmp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_chain[gi] <= 1'b0;
                    end else begin
                        r_chain[gi] <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_chain[gi] <= 1'b0;
                    end else begin
                        r_chain[gi] <= r_chain[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/cmp_stream_decimator.sv
// Comparator bit-stream decimator: counts ones over a 2^L-sample window and
// emits a saturated 8-bit density code, single-shot or back-to-back.
module cmp_stream_decimator
    import cmp_pkg::*;
#(
    parameter int WIN_MIN_LOG2 = WIN_MIN_LOG2_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cmp_in,
    input  logic                start,
    input  logic                cont,
    input  logic [1:0]          osr_sel,
    output logic [RESULT_W-1:0] result,
    output logic                valid,
    output logic                busy
);

    // Counters must hold the largest window length (2^(WIN_MIN_LOG2+3)).
    localparam int CW = (WIN_MIN_LOG2 + 4 > CNT_W) ? (WIN_MIN_LOG2 + 4) : CNT_W;
    localparam int SW = $clog2(SYNC_STAGES + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_win_sel;
    logic [1:0]          w_win_sel_next;
    logic [CW-1:0]       r_sample_cnt;
    logic [CW-1:0]       w_sample_cnt_next;
    logic [CW-1:0]       r_ones_cnt;
    logic [CW-1:0]       w_ones_cnt_next;
    logic [CW-1:0]       w_ones_inc;
    logic [CW-1:0]       w_last_idx;
    logic [SW-1:0]       r_settle_cnt;
    logic [SW-1:0]       w_settle_cnt_next;
    logic [RESULT_W-1:0] r_result;
    logic [RESULT_W-1:0] w_result_next;
    logic                w_s;
    logic                w_last;

    cmp_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cmp_in),
        .q    (w_s)
    );

    assign w_ones_inc = r_ones_cnt + CW'(w_s);
    assign w_last_idx = CW'((64'd1 << (WIN_MIN_LOG2 + int'(r_win_sel))) - 64'd1);
    assign w_last     = (r_sample_cnt == w_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_win_sel    <= 2'd0;
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
            r_settle_cnt <= '0;
            r_result     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_win_sel    <= w_win_sel_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_ones_cnt   <= w_ones_cnt_next;
            r_settle_cnt <= w_settle_cnt_next;
            r_result     <= w_result_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_win_sel_next    = r_win_sel;
        w_sample_cnt_next = r_sample_cnt;
        w_ones_cnt_next   = r_ones_cnt;
        w_settle_cnt_next = r_settle_cnt;
        w_result_next     = r_result;

        if (!ena) begin
            // Abort: the partial window is discarded and result keeps its value.
            w_state_next      = IDLE;
            w_sample_cnt_next = '0;
            w_ones_cnt_next   = '0;
            w_settle_cnt_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_win_sel_next    = osr_sel;
                        w_sample_cnt_next = '0;
                        w_ones_cnt_next   = '0;
                        w_settle_cnt_next = '0;
                        w_state_next      = SETTLE;
                    end
                end
                SETTLE: begin
                    // Flush whatever the synchronizer held before the request.
                    if (r_settle_cnt == SW'(SYNC_STAGES - 1)) begin
                        w_settle_cnt_next = '0;
                        w_state_next      = ACCUM;
                    end else begin
                        w_settle_cnt_next = r_settle_cnt + SW'(1);
                    end
                end
                ACCUM: begin
                    w_sample_cnt_next = r_sample_cnt + CW'(1);
                    w_ones_cnt_next   = w_ones_inc;
                    if (w_last) begin
                        // Code is registered on entry so it is already valid during DONE.
                        w_result_next = scale_code(32'(w_ones_inc),
                                                   WIN_MIN_LOG2 + int'(r_win_sel));
                        w_state_next  = DONE;
                    end
                end
                DONE: begin
                    w_sample_cnt_next = '0;
                    w_ones_cnt_next   = '0;
                    if (cont) begin
                        w_win_sel_next = osr_sel;
                        w_state_next   = ACCUM;
                    end else begin
                        w_state_next   = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign valid  = (r_state == DONE);
    assign busy   = (r_state == SETTLE) || (r_state == ACCUM);

endmodule

// File: tb/tb_cmp_stream_decimator.sv
// Scoreboard bench for the comparator stream decimator: expected codes and
// valid cycles are queued at start and checked when valid appears.
module tb_cmp_stream_decimator;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ena     = 1'b0;
    logic       cmp_in  = 1'b0;
    logic       start   = 1'b0;
    logic       cont    = 1'b0;
    logic [1:0] osr_sel = 2'd0;
    logic [7:0] result;
    logic       valid;
    logic       busy;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int cyc      = 0;
    int n_valid  = 0;
    int busy_cnt = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    int pat_idx  = 0;
    int pat_mode = 0;   // 0 zeros, 1 ones, 2 toggle, 3 pattern 1110
    int vb       = 0;
    int c0       = 0;

    cmp_stream_decimator dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .cmp_in (cmp_in),
        .start  (start),
        .cont   (cont),
        .osr_sel(osr_sel),
        .result (result),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, expv, cyc);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (valid === 1'b1) begin
            n_valid++;
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", 32'(valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("result", 32'(result), 32'(mon_e.res));
                check_eq("valid_cycle", cyc, mon_e.cyc);
                $display("[TB] valid cyc=%0d result=0x%02h expected=0x%02h", cyc, result, mon_e.res);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        pat_idx++;
        case (pat_mode)
            0:       cmp_in = 1'b0;
            1:       cmp_in = 1'b1;
            2:       cmp_in = pat_idx[0];
            default: cmp_in = (pat_idx[1:0] != 2'b11);
        endcase
    endtask

    task automatic push_exp(input logic [7:0] res, input int at_cyc);
        exp_t e;
        e.res = res;
        e.cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic start_conv(input int mode, input logic [1:0] osr,
                              input logic [7:0] expv, input bit expect_it);
        pat_mode = mode;
        osr_sel  = osr;
        // start sampled next edge; valid follows 2 settle + N accumulate edges
        if (expect_it) push_exp(expv, cyc + 3 + (1 << (5 + int'(osr))));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valids(input int target, input int budget);
        int n;
        n = 0;
        while (n_valid < target && n < budget) begin
            tick();
            n++;
        end
        if (n_valid < target) check_eq("timeout", n_valid, target);
    endtask

    initial begin
        int tbl_mode [5] = '{2, 2, 3, 2, 3};
        int tbl_osr  [5] = '{3, 1, 2, 0, 3};
        int tbl_exp  [5] = '{8'h80, 8'h80, 8'hC0, 8'h80, 8'hC0};

        repeat (3) tick();
        check_eq("rst_result", 32'(result), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick();

        // All ones, 32 samples: 32<<3 saturates
        busy_cnt = 0;
        start_conv(1, 2'd0, 8'hFF, 1'b1);
        wait_valids(1, 100);
        check_eq("busy_cycles", busy_cnt, 34);
        tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid", 32'(valid), 32'd0);
        tick();

        for (int i = 0; i < 5; i++) begin
            vb = n_valid;
            start_conv(tbl_mode[i], 2'(tbl_osr[i]), 8'(tbl_exp[i]), 1'b1);
            wait_valids(vb + 1, 400);
            tick();
            tick();
        end

        // Free-running zeros at 64 samples; osr_sel moved to 0 during window 3
        vb = n_valid;
        c0 = cyc;
        cont     = 1'b1;
        pat_mode = 0;
        osr_sel  = 2'd1;
        push_exp(8'h00, c0 + 67);
        push_exp(8'h00, c0 + 132);
        push_exp(8'h00, c0 + 197);
        push_exp(8'h00, c0 + 230);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valids(vb + 2, 300);
        tick();
        tick();
        osr_sel = 2'd0;
        wait_valids(vb + 3, 200);
        tick();
        tick();
        cont = 1'b0;
        wait_valids(vb + 4, 200);
        tick();
        tick();
        check_eq("cont_end_busy", 32'(busy), 32'd0);
        repeat (80) tick();
        check_eq("cont_tail_valids", n_valid, vb + 4);

        // ena abort at sample 10 keeps the previous 0x80
        vb = n_valid;
        start_conv(2, 2'd0, 8'h80, 1'b1);
        wait_valids(vb + 1, 100);
        tick();
        tick();
        vb = n_valid;
        start_conv(1, 2'd0, 8'h00, 1'b0);
        repeat (12) tick();
        ena = 1'b0;
        tick();
        check_eq("abort_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        repeat (60) tick();
        check_eq("abort_result", 32'(result), 32'h80);
        check_eq("abort_no_valid", n_valid, vb);
        start_conv(1, 2'd0, 8'hFF, 1'b1);
        wait_valids(vb + 1, 100);
        tick();
        tick();

        // start with ena low is ignored
        ena = 1'b0;
        start_conv(1, 2'd0, 8'h00, 1'b0);
        repeat (5) tick();
        check_eq("ena_low_start_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        tick();

        // osr_sel change mid-window takes effect at the next start
        vb = n_valid;
        start_conv(2, 2'd0, 8'h80, 1'b1);
        repeat (5) tick();
        osr_sel = 2'd3;
        wait_valids(vb + 1, 100);
        tick();
        tick();
        start_conv(3, 2'd3, 8'hC0, 1'b1);
        wait_valids(vb + 2, 400);
        tick();
        tick();

        // Asynchronous reset in the middle of ACCUM
        vb = n_valid;
        start_conv(1, 2'd3, 8'h00, 1'b0);
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_result", 32'(result), 32'h00);
        check_eq("arst_valid", 32'(valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("arst_no_valid", n_valid, vb);

        // Second start pulse during SETTLE must not restart the window
        start_conv(1, 2'd0, 8'hFF, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valids(vb + 1, 100);
        tick();
        tick();

        check_eq("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
